// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute-stage ALU.
// Opcodes, FSM states and the shift-amount width helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_FWD = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLL = 3'd4,
    OP_SRA = 3'd5,
    OP_ROR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int amt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// START/BUSY/DONE handshake and data bus of the multi-cycle ALU.
// The control unit is master, the ALU is slave.
interface multicycle_alu_if #(
  parameter int N = 8,
  parameter int S = 3
);
  logic         START;
  logic [N-1:0] DATA1;
  logic [N-1:0] DATA2;
  logic [S-1:0] SELECT;
  logic [N-1:0] RESULT;
  logic [N-1:0] RESULT_HI;
  logic         ZERO;
  logic         BUSY;
  logic         DONE;

  modport master (
    output START, DATA1, DATA2, SELECT,
    input  RESULT, RESULT_HI, ZERO, BUSY, DONE
  );

  modport slave (
    input  START, DATA1, DATA2, SELECT,
    output RESULT, RESULT_HI, ZERO, BUSY, DONE
  );
endinterface

// File: rtl/shift_add_mul.sv
// Radix-2 shift-add unsigned multiplier, one step per cycle.
// lo_o/hi_o present the product as it will be after the current step.
module shift_add_mul #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] mcand_i,
  input  logic [N-1:0] mplr_i,
  output logic [N-1:0] lo_o,
  output logic [N-1:0] hi_o,
  output logic         last_o
);
  localparam int CW = $clog2(N);

  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mplr_q, mplr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    sum;

  // {carry, acc, multiplier} shifts right once per step
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    sum     = {1'b0, acc_q}
            + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    if (load) begin
      mcand_d = mcand_i;
      mplr_d  = mplr_i;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (step) begin
      acc_d  = sum[N:1];
      mplr_d = {sum[0], mplr_q[N-1:1]};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  assign lo_o   = {sum[0], mplr_q[N-1:1]};
  assign hi_o   = sum[N:1];
  assign last_o = step && (cnt_q == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/add,
// bit-serial shifts/rotates and an iterative N x N multiplier.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 3
) (
  input logic             CLK,
  input logic             RESET,
  multicycle_alu_if.slave bus
);
  localparam int AW = amt_w(N);
  localparam logic [AW-1:0] N_AMT = AW'(N);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [N-1:0]  work_q, work_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  result_hi_q, result_hi_d;
  logic          zero_q, zero_d;
  logic          done_q, done_d;

  op_e           op_in;
  logic [AW-1:0] amt;
  logic [AW-1:0] c_in;
  logic [N-1:0]  imm;
  logic [N-1:0]  shifted;
  logic          mul_load, mul_step, mul_last;
  logic [N-1:0]  mul_lo, mul_hi;

  assign op_in = op_e'(bus.SELECT[2:0]);
  assign amt   = bus.DATA1[AW-1:0];

  // SLL/SRA saturate at N; ROR wraps modulo N
  always_comb begin
    c_in = '0;
    unique case (op_in)
      OP_SLL, OP_SRA: c_in = (amt > N_AMT) ? N_AMT : amt;
      OP_ROR:         c_in = {1'b0, amt[AW-2:0]};
      default:        c_in = '0;
    endcase
  end

  always_comb begin
    imm = bus.DATA1;
    unique case (op_in)
      OP_ADD:  imm = bus.DATA1 + bus.DATA2;
      OP_AND:  imm = bus.DATA1 & bus.DATA2;
      OP_OR:   imm = bus.DATA1 | bus.DATA2;
      default: imm = bus.DATA1;
    endcase
  end

  always_comb begin
    shifted = work_q;
    unique case (op_q)
      OP_SLL:  shifted = {work_q[N-2:0], 1'b0};
      OP_SRA:  shifted = {work_q[N-1], work_q[N-1:1]};
      OP_ROR:  shifted = {work_q[0], work_q[N-1:1]};
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    done_d      = 1'b0;
    mul_load    = 1'b0;
    mul_step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          op_d = op_in;
          unique case (op_in)
            OP_SLL, OP_SRA, OP_ROR: begin
              if (c_in == '0) begin
                result_d    = bus.DATA2;
                result_hi_d = '0;
                zero_d      = (bus.DATA2 == '0);
                done_d      = 1'b1;
              end else begin
                work_d  = bus.DATA2;
                cnt_d   = c_in;
                state_d = ST_RUN;
              end
            end
            OP_MUL: begin
              mul_load = 1'b1;
              state_d  = ST_RUN;
            end
            default: begin
              result_d    = imm;
              result_hi_d = '0;
              zero_d      = (imm == '0);
              done_d      = 1'b1;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (op_q == OP_MUL) begin
          mul_step = 1'b1;
          if (mul_last) begin
            result_d    = mul_lo;
            result_hi_d = mul_hi;
            zero_d      = ({mul_hi, mul_lo} == '0);
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end
        end else begin
          work_d = shifted;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == AW'(1)) begin
            result_d    = shifted;
            result_hi_d = '0;
            zero_d      = (shifted == '0);
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  shift_add_mul #(.N(N)) u_mul (
    .clk     (CLK),
    .rst     (RESET),
    .load    (mul_load),
    .step    (mul_step),
    .mcand_i (bus.DATA1),
    .mplr_i  (bus.DATA2),
    .lo_o    (mul_lo),
    .hi_o    (mul_hi),
    .last_o  (mul_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_FWD;
      work_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      done_q      <= done_d;
    end
  end

  assign bus.RESULT    = result_q;
  assign bus.RESULT_HI = result_hi_q;
  assign bus.ZERO      = zero_q;
  assign bus.BUSY      = (state_q == ST_RUN);
  assign bus.DONE      = done_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: vector table plus
// hand-written handshake/reset corner sequences.
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_alu_if #(.N(8), .S(3)) bus ();

  multicycle_alu #(.N(8), .S(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [2:0] sel;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] res;
    logic [7:0] hi;
    logic       zero;
    int         lat;
    int         busy;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Issue one op and wait for DONE; lat counts START->DONE cycles
  task automatic do_op(input logic [2:0] sel, input logic [7:0] d1,
                       input logic [7:0] d2, output int lat,
                       output int busy);
    @(negedge clk);
    bus.START = 1'b1; bus.SELECT = sel;
    bus.DATA1 = d1;   bus.DATA2 = d2;
    @(posedge clk); #1;
    bus.START = 1'b0;
    bus.DATA1 = 8'hA5; bus.DATA2 = 8'h5A; bus.SELECT = 3'd1;
    lat = 1; busy = 0;
    while (!bus.DONE && lat < 40) begin
      if (bus.BUSY) busy++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.BUSY) busy++;
  endtask

  vec_t vt[$];
  int   lat, busy, dones;

  initial begin
    bus.START = 1'b0; bus.SELECT = '0;
    bus.DATA1 = '0;   bus.DATA2 = '0;

    vt.push_back('{"add",      3'd1, 8'hF0, 8'h20, 8'h10, 8'h00, 1'b0, 1, 0});
    vt.push_back('{"add_wrap", 3'd1, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1, 0});
    vt.push_back('{"fwd",      3'd0, 8'h00, 8'h55, 8'h00, 8'h00, 1'b1, 1, 0});
    vt.push_back('{"and",      3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1, 0});
    vt.push_back('{"or",       3'd3, 8'h0F, 8'h30, 8'h3F, 8'h00, 1'b0, 1, 0});
    vt.push_back('{"mul_ff",   3'd7, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 9, 8});
    vt.push_back('{"fwd_hi0",  3'd0, 8'h42, 8'h00, 8'h42, 8'h00, 1'b0, 1, 0});
    vt.push_back('{"mul_zero", 3'd7, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b1, 9, 8});
    vt.push_back('{"mul_d_b",  3'd7, 8'h0D, 8'h0B, 8'h8F, 8'h00, 1'b0, 9, 8});
    vt.push_back('{"mul_hi",   3'd7, 8'h80, 8'h02, 8'h00, 8'h01, 1'b0, 9, 8});
    vt.push_back('{"sra3",     3'd5, 8'h03, 8'h90, 8'hF2, 8'h00, 1'b0, 4, 3});
    vt.push_back('{"sra12",    3'd5, 8'h0C, 8'h90, 8'hFF, 8'h00, 1'b0, 9, 8});
    vt.push_back('{"ror9",     3'd6, 8'h09, 8'h81, 8'hC0, 8'h00, 1'b0, 2, 1});
    vt.push_back('{"ror8",     3'd6, 8'h08, 8'h81, 8'h81, 8'h00, 1'b0, 1, 0});
    vt.push_back('{"sll0",     3'd4, 8'h00, 8'h01, 8'h01, 8'h00, 1'b0, 1, 0});
    vt.push_back('{"sll8",     3'd4, 8'h08, 8'h01, 8'h00, 8'h00, 1'b1, 9, 8});
    vt.push_back('{"sll3",     3'd4, 8'h03, 8'h81, 8'h08, 8'h00, 1'b0, 4, 3});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.RESULT, 8'h00);
    chk("rst_hi", bus.RESULT_HI, 8'h00);
    chk("rst_zero", bus.ZERO, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      do_op(vt[i].sel, vt[i].d1, vt[i].d2, lat, busy);
      chk({vt[i].name, "_lat"}, lat, vt[i].lat);
      chk({vt[i].name, "_busy"}, busy, vt[i].busy);
      chk({vt[i].name, "_res"}, bus.RESULT, vt[i].res);
      chk({vt[i].name, "_hi"}, bus.RESULT_HI, vt[i].hi);
      chk({vt[i].name, "_zero"}, bus.ZERO, vt[i].zero);
      @(posedge clk); #1;
      chk({vt[i].name, "_pulse"}, bus.DONE, 1'b0);
      chk({vt[i].name, "_hold"}, bus.RESULT, vt[i].res);
    end

    // START during MUL RUN is dropped
    @(negedge clk);
    bus.START = 1'b1; bus.SELECT = 3'd7;
    bus.DATA1 = 8'h03; bus.DATA2 = 8'h05;
    @(negedge clk);
    bus.START = 1'b0;
    dones = 0;
    repeat (2) @(negedge clk);
    bus.START = 1'b1; bus.SELECT = 3'd1;
    bus.DATA1 = 8'h11; bus.DATA2 = 8'h22;
    @(negedge clk);
    bus.START = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (bus.DONE) dones++;
      if (bus.DONE) chk("ign_res", bus.RESULT, 8'h0F);
    end
    chk("ign_dones", dones, 1);

    // Reset mid-MUL aborts without DONE
    @(negedge clk);
    bus.START = 1'b1; bus.SELECT = 3'd7;
    bus.DATA1 = 8'hFF; bus.DATA2 = 8'hFF;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", bus.BUSY, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", bus.BUSY, 1'b0);
    chk("abort_res", bus.RESULT, 8'h00);
    chk("abort_hi", bus.RESULT_HI, 8'h00);
    chk("abort_done", bus.DONE, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.DONE) dones++;
    end
    chk("abort_nodone", dones, 0);

    // START in the DONE cycle is accepted
    @(negedge clk);
    bus.START = 1'b1; bus.SELECT = 3'd1;
    bus.DATA1 = 8'h01; bus.DATA2 = 8'h02;
    @(posedge clk); #1;
    chk("b2b_done1", bus.DONE, 1'b1);
    chk("b2b_res1", bus.RESULT, 8'h03);
    bus.SELECT = 3'd5; bus.DATA1 = 8'h01; bus.DATA2 = 8'h80;
    @(posedge clk); #1;
    bus.START = 1'b0;
    chk("b2b_busy", bus.BUSY, 1'b1);
    chk("b2b_nodone", bus.DONE, 1'b0);
    @(posedge clk); #1;
    chk("b2b_done2", bus.DONE, 1'b1);
    chk("b2b_res2", bus.RESULT, 8'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
